divider: RTL
============

# divider

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the single-cycle ALU in the execute stage. It is a control-dominated block: an FSM and bit counter sequence one shift-subtract step per cycle through a shared (XLEN+1)-bit subtractor. Divide-by-zero and signed overflow are resolved on a fast path. The execute stage stalls on `div_ready`/`div_done` and can squash an in-flight divide with `div_flush`.

## Interface
- `XLEN`, default 32: operand/result width; taken from `config.svh`.
- `clk`  in  1  core clock; all state on rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `div_req`  in  1  request valid; operands and opcode are sampled when `div_req & div_ready`.
- `div_opcode`  in  2  operation select: 0 = DIV, 1 = DIVU, 2 = REM, 3 = REMU.
- `div_src1`  in  XLEN  dividend.
- `div_src2`  in  XLEN  divisor.
- `div_flush`  in  1  abort any in-flight operation.
- `div_ready`  out  1  high only in IDLE.
- `div_busy`  out  1  high in CALC or DONE.
- `div_done`  out  1  one-cycle result-valid pulse; there is no back-pressure.
- `div_result`  out  XLEN  quotient or remainder; valid only while `div_done`=1, 0 otherwise.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - Accept on `div_req & ~div_flush`.
  - Latch opcode, sign flags, |src1| and |src2|. Magnitudes are two's-complement negated only for signed ops with a negative operand.
  - If divisor = 0 or signed overflow (src1 = 0x80000000, src2 = 0xFFFFFFFF, DIV/REM), go to DONE with a fast flag set.
  - Otherwise go to CALC and load counter = XLEN-1.
- **CALC step (one per cycle):**
  - rem_sh = {rem[XLEN-1:0], quo[XLEN-1]}.
  - diff = rem_sh − {1'b0, divisor}, XLEN+1 bits.
  - If diff[XLEN] = 0: rem ← diff, shift 1 into quo. Else: rem ← rem_sh, shift 0 into quo.
  - Counter decrements; when counter = 0 the step is still performed and the FSM goes to DONE.
- **DONE:** assert `div_done` with the result below, then return to IDLE.
  - Quotient is negated if signed op and operand signs differ.
  - Remainder takes the dividend's sign, i.e. negated if signed op and dividend negative.
  - Divide by zero: quotient = all ones (both signed and unsigned); remainder = src1 unmodified.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- **Flush:** `div_flush` in any state sends the FSM to IDLE next cycle, with no `div_done` and internal data don't-care. Flush in the same cycle as `div_req` drops the request.
- **Reset (including mid-operation):** state = IDLE, counter = 0, `div_done` = 0, `div_result` = 0, `div_ready` = 1, `div_busy` = 0.

## Timing
- Request accepted at cycle T.
- **Normal path:** CALC during T+1…T+XLEN; `div_done` at T+XLEN+1 (T+33 for XLEN = 32); `div_ready` again at T+XLEN+2.
- **Fast path:** `div_done` at T+1; `div_ready` at T+2.
- `div_ready` is a registered-state decode. There is no combinational path from `div_req` to `div_ready`.
- Back-to-back requests: the earliest next accept is the cycle after `div_done`.
- Result negation is combinational from registers in DONE. The subtractor is the only XLEN+1-bit adder on the CALC path.

## Structure
- Shared defines in `core.svh`:
  - `DIV_OP_WIDTH` = 2 and the four `DIV_OP_*` encodings.
  - State enum `div_state_t` {IDLE, CALC, DONE}.
- Single module, no sub-modules. The magnitude/negate helper is a local function.
- Registers:
  - state
  - counter ($clog2(XLEN) bits)
  - quo (XLEN)
  - rem (XLEN+1)
  - divisor (XLEN)
  - opcode
  - neg_q, neg_r
  - fast flag plus fast result

## Test plan
- DIV 100 / 7 accepted at T → `div_done` only at T+33, result 14. REM on the same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- DIV 5 / 0 → `div_done` at T+1, result 0xFFFFFFFF. REMU 5 / 0 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1. REM on the same operands → 0.
- `div_flush` at T+10 → no `div_done`, `div_ready` = 1 at T+11. A new DIVU 9 / 3 accepted at T+11 → 3 at T+44.
- `rst_b` asserted at T+5 mid-CALC → all outputs at reset values immediately. After release, the next request completes normally. Also: `div_req` together with `div_flush` → not accepted.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared opcode encodings and FSM state type for the
// iterative RV32M divider.
package divider_pkg;

  localparam int DIV_OP_WIDTH = 2;

  typedef enum logic [DIV_OP_WIDTH-1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic logic op_signed(
    input logic [DIV_OP_WIDTH-1:0] op
  );
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(
    input logic [DIV_OP_WIDTH-1:0] op
  );
    return op[1];
  endfunction

endpackage

// File: rtl/divider_if.sv
// Execute-stage <-> divider request/result bundle.
// master = execute stage, slave = divider.
interface divider_if #(
  parameter int XLEN = 32
) ();
  import divider_pkg::*;

  logic                    div_req;
  logic [DIV_OP_WIDTH-1:0] div_opcode;
  logic [XLEN-1:0]         div_src1;
  logic [XLEN-1:0]         div_src2;
  logic                    div_flush;
  logic                    div_ready;
  logic                    div_busy;
  logic                    div_done;
  logic [XLEN-1:0]         div_result;

  modport master (
    output div_req,
    output div_opcode,
    output div_src1,
    output div_src2,
    output div_flush,
    input  div_ready,
    input  div_busy,
    input  div_done,
    input  div_result
  );

  modport slave (
    input  div_req,
    input  div_opcode,
    input  div_src1,
    input  div_src2,
    input  div_flush,
    output div_ready,
    output div_busy,
    output div_done,
    output div_result
  );

endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One shift-subtract step per cycle; div-by-zero and overflow bypass CALC.
module divider
  import divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_b,
  divider_if.slave   dif
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE =
    {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] SMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  div_state_t r_state;
  div_state_t w_next;

  logic [CW-1:0]           r_cnt;
  logic [XLEN-1:0]         r_quo;
  logic [XLEN-1:0]         r_rem;
  logic [XLEN-1:0]         r_dvs;
  logic [DIV_OP_WIDTH-1:0] r_op;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_fast;
  logic [XLEN-1:0]         r_fast_res;

  logic            w_accept;
  logic            w_sgn;
  logic            w_s1n;
  logic            w_s2n;
  logic [XLEN-1:0] w_a1;
  logic [XLEN-1:0] w_a2;
  logic            w_dz;
  logic            w_ovf;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_res;

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] v,
    input logic            n
  );
    return n ? (~v + ONE) : v;
  endfunction

  assign w_accept = dif.div_req & ~dif.div_flush
                  & (r_state == IDLE);
  assign w_sgn = op_signed(dif.div_opcode);
  assign w_s1n = w_sgn & dif.div_src1[XLEN-1];
  assign w_s2n = w_sgn & dif.div_src2[XLEN-1];
  assign w_a1  = mag(dif.div_src1, w_s1n);
  assign w_a2  = mag(dif.div_src2, w_s2n);
  assign w_dz  = (dif.div_src2 == '0);
  assign w_ovf = w_sgn & (dif.div_src1 == SMIN)
               & (&dif.div_src2);

  always_comb begin
    w_fast_res = '0;
    if (w_dz)
      w_fast_res = op_is_rem(dif.div_opcode)
                 ? dif.div_src1 : '1;
    else if (w_ovf)
      w_fast_res = op_is_rem(dif.div_opcode)
                 ? '0 : SMIN;
  end

  // The only XLEN+1 adder on the iteration path.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[XLEN];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept)
              w_next = (w_dz | w_ovf) ? DONE : CALC;
      CALC: if (r_cnt == '0)
              w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (dif.div_flush)
      w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_op       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_res <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_op       <= dif.div_opcode;
          r_neg_q    <= w_s1n ^ w_s2n;
          r_neg_r    <= w_s1n;
          r_quo      <= w_a1;
          r_rem      <= '0;
          r_dvs      <= w_a2;
          r_fast     <= w_dz | w_ovf;
          r_fast_res <= w_fast_res;
          r_cnt      <= CW'(XLEN-1);
        end
        CALC: begin
          r_rem <= w_ge ? w_diff[XLEN-1:0]
                        : w_rem_sh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_res = '0;
    if (r_fast)
      w_res = r_fast_res;
    else begin
      unique case (r_op)
        DIV_OP_DIV,
        DIV_OP_DIVU: w_res = mag(r_quo, r_neg_q);
        DIV_OP_REM,
        DIV_OP_REMU: w_res = mag(r_rem, r_neg_r);
        default:     w_res = '0;
      endcase
    end
  end

  // A flush landing on DONE suppresses the pulse.
  assign dif.div_ready  = (r_state == IDLE);
  assign dif.div_busy   = (r_state == CALC)
                        | (r_state == DONE);
  assign dif.div_done   = (r_state == DONE)
                        & ~dif.div_flush;
  assign dif.div_result = dif.div_done ? w_res : '0;

endmodule
